mips_multicycle_core: RTL

//  Multicycle MIPS core: one registered datapath plus its own control FSM, in place of
//  the single-cycle datapath and its external decoder.
//  A single unified memory port serves both fetch and data, with a ready handshake for

---
 rtl/mips_multicycle_core.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core: registered datapath sequenced by a two-process control FSM,
// sharing one memory port between instruction fetch and data access.
module mips_multicycle_core #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_req,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc_out,
  output logic            halted
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_ADDI, S_ADDIWB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d, mdr_q, mdr_d;
  logic [XLEN-1:0] rf_q [32];

  logic            rf_we;
  logic [4:0]      rf_wa;
  logic [XLEN-1:0] rf_wd;

  logic [5:0]      opcode;
  logic [4:0]      rs, rt, rd;
  logic [XLEN-1:0] signimm;
  logic [2:0]      alu_ctrl;
  logic            funct_ok;
  logic            unused_shamt;

  assign opcode       = ir_q[31:26];
  assign rs           = ir_q[25:21];
  assign rt           = ir_q[20:16];
  assign rd           = ir_q[15:11];
  assign signimm      = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
  assign unused_shamt = ^ir_q[10:6];

  function automatic logic [XLEN-1:0] alu(input logic [2:0] ctrl,
                                          input logic [XLEN-1:0] x,
                                          input logic [XLEN-1:0] y);
    case (ctrl)
      3'b010:  alu = x + y;
      3'b110:  alu = x - y;
      3'b000:  alu = x & y;
      3'b001:  alu = x | y;
      3'b111:  alu = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
      default: alu = '0;
    endcase
  endfunction

  always_comb begin
    alu_ctrl = 3'b010;
    funct_ok = 1'b1;
    case (ir_q[5:0])
      6'h20:   alu_ctrl = 3'b010;
      6'h22:   alu_ctrl = 3'b110;
      6'h24:   alu_ctrl = 3'b000;
      6'h25:   alu_ctrl = 3'b001;
      6'h2A:   alu_ctrl = 3'b111;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_wa    = '0;
    rf_wd    = '0;
    case (state_q)
      S_FETCH: if (mem_ready) begin
        ir_d    = mem_rdata[31:0];
        pc_d    = pc_q + FOUR;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d      = (rs == 5'd0) ? '0 : rf_q[rs];
        b_d      = (rt == 5'd0) ? '0 : rf_q[rt];
        aluout_d = pc_q + (signimm << 2);
        case (opcode)
          OP_RTYPE:     state_d = funct_ok ? S_EXEC : S_TRAP;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        aluout_d = a_q + signimm;
        state_d  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: if (mem_ready) begin
        mdr_d   = mem_rdata;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rf_we = 1'b1; rf_wa = rt; rf_wd = mdr_q; state_d = S_FETCH;
      end
      S_MEMWR: if (mem_ready) state_d = S_FETCH;
      S_EXEC: begin
        aluout_d = alu(alu_ctrl, a_q, b_q);
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we = 1'b1; rf_wa = rd; rf_wd = aluout_q; state_d = S_FETCH;
      end
      S_ADDI: begin
        aluout_d = a_q + signimm;
        state_d  = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we = 1'b1; rf_wa = rt; rf_wd = aluout_q; state_d = S_FETCH;
      end
      S_BRANCH: begin
        if (a_q == b_q) pc_d = aluout_q;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Bus outputs are pure functions of registered state, so they stay put during wait states.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_q;
    case (state_q)
      S_FETCH: mem_req = 1'b1;
      S_MEMRD: begin mem_req = 1'b1; mem_addr = aluout_q; end
      S_MEMWR: begin mem_req = 1'b1; mem_we = 1'b1; mem_addr = aluout_q; end
      default: ;
    endcase
    if (reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  assign mem_wdata = b_q;
  assign pc_out    = pc_q;
  assign halted    = (state_q == S_TRAP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
      if (rf_we && rf_wa != 5'd0) rf_q[rf_wa] <= rf_wd;
    end
  end

endmodule
